// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and
// the default address window, plus the alignment/legality check used at accept.
package mem_access_pkg;

    localparam int unsigned DEFAULT_ADDR_LIMIT = 4096;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // True when the size encoding is illegal or the address is not naturally aligned.
    function automatic logic sizeFault(input size_e size, input logic [1:0] addrLow);
        case (size)
            SIZE_HALF:    return addrLow[0];
            SIZE_WORD:    return addrLow != 2'b00;
            SIZE_ILLEGAL: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane extraction (loads) and lane merge (sub-word stores)
// between a buffered memory word and right-justified request data.
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] wordIn,
    input  logic [1:0]  addrLow,
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [31:0] storeData,
    output logic [31:0] loadData,
    output logic [31:0] mergedWord
);

    logic [4:0]  byteShift;
    logic [4:0]  halfShift;
    logic [31:0] shifted;

    assign byteShift = {addrLow, 3'b000};
    assign halfShift = {addrLow[1], 4'b0000};
    assign shifted   = wordIn >> byteShift;

    // Word accesses pass straight through; sub-word sizes extend on load and
    // splice only the addressed lanes on store.
    always_comb begin
        loadData   = shifted;
        mergedWord = storeData;
        case (size_e'(size))
            SIZE_BYTE: begin
                loadData   = {{24{isSigned & shifted[7]}}, shifted[7:0]};
                mergedWord = (wordIn & ~(32'h0000_00FF << byteShift))
                           | ({24'b0, storeData[7:0]} << byteShift);
            end
            SIZE_HALF: begin
                loadData   = {{16{isSigned & shifted[15]}}, shifted[15:0]};
                mergedWord = (wordIn & ~(32'h0000_FFFF << halfShift))
                           | ({16'b0, storeData[15:0]} << halfShift);
            end
            default: begin
                loadData   = shifted;
                mergedWord = storeData;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a single-port word memory;
// sub-word stores are done as read-modify-write through an internal buffer.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    output logic [31:0] respRData,
    output logic        respErr,
    output logic        memWriteEn,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    state_e      state_q;
    logic        write_q;
    size_e       size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic        err_q;

    logic        reqErr_d;
    logic [31:0] loadData;
    logic [31:0] mergedWord;

    assign reqErr_d = sizeFault(size_e'(reqSize), reqAddr[1:0]) || (reqAddr >= ADDR_LIMIT);

    // Only word stores skip the read; every other legal access fills the buffer first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            buf_q    <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        write_q  <= reqWrite;
                        size_q   <= size_e'(reqSize);
                        signed_q <= reqSigned;
                        addr_q   <= reqAddr;
                        wdata_q  <= reqWData;
                        err_q    <= reqErr_d;
                        if (reqErr_d)
                            state_q <= RESP;
                        else if (reqWrite && size_e'(reqSize) == SIZE_WORD)
                            state_q <= WRITE;
                        else
                            state_q <= READ;
                    end
                end
                READ: begin
                    buf_q   <= memReadData;
                    state_q <= write_q ? WRITE : RESP;
                end
                WRITE:   state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    mau_lane_align u_align (
        .wordIn     (buf_q),
        .addrLow    (addr_q[1:0]),
        .size       (size_q),
        .isSigned   (signed_q),
        .storeData  (wdata_q),
        .loadData   (loadData),
        .mergedWord (mergedWord)
    );

    // The write strobe also looks at rst_n so a reset landing on WRITE kills the store.
    assign reqReady     = (state_q == IDLE);
    assign respValid    = (state_q == RESP);
    assign respErr      = respValid && err_q;
    assign respRData    = (respValid && !err_q && !write_q) ? loadData : 32'h0;
    assign memWriteEn   = (state_q == WRITE) && rst_n;
    assign memAddress   = {addr_q[31:2], 2'b00};
    assign memWriteData = (state_q == WRITE) ? mergedWord : 32'h0;

endmodule
